// File: rtl/ay_seq_pkg.sv
// Shared types and constants for the AY/YM2149 bus sequencer: FSM states,
// command entry layout and the per-register write masks.
package ay_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } seq_state_e;

    localparam logic CMD_ADDR = 1'b1;
    localparam logic CMD_DATA = 1'b0;

    localparam int unsigned CMD_W = 9;

    typedef struct packed {
        logic       is_addr;
        logic [7:0] data;
    } cmd_t;

    // Index 0 is the rightmost element: R0 .. R15
    localparam logic [15:0][7:0] REG_MASK = {
        8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'h1F, 8'h1F, 8'h1F,
        8'hFF, 8'h1F, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF
    };

endpackage

// File: rtl/ay_cmd_fifo.sv
// Show-ahead command FIFO; a push while full is accepted only when a pop
// frees a slot in the same clk.
module ay_cmd_fifo
    import ay_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [CMD_W-1:0] din,
    input  logic             pop,
    output logic [CMD_W-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][CMD_W-1:0]  mem_q, mem_d;
    logic                         do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/ay_bus_sequencer.sv
// Buffers CPU writes to the AY ports and replays them as phased BDIR/BC cycles,
// one phase per clock enable; CPU reads are served from a masked shadow copy.
module ay_bus_sequencer
    import ay_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  PORT_BASE  = 8'h14
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] shavv,
    input  logic [7:0] data,
    input  logic       negedge_zpvv_n,
    input  logic       negedge_chtvv_n,
    input  logic       ce,
    output logic [7:0] ym_di,
    output logic       ym_bdir,
    output logic       ym_bc,
    output logic [7:0] data_o,
    output logic       busy,
    output logic       overflow
);

    seq_state_e       state_q, state_d;
    logic [7:0]       cpu_addr_q, cpu_addr_d;
    logic [15:0][7:0] shadow_q, shadow_d;
    logic [7:0]       data_o_q, data_o_d;
    logic [7:0]       ym_di_q, ym_di_d;
    logic             is_addr_q, is_addr_d;
    logic             ym_bdir_q, ym_bc_q, overflow_q, overflow_d;

    logic  sel, wr, rd;
    logic  push_req, pop;
    cmd_t  push_entry, head;
    logic  fifo_full, fifo_empty;

    assign sel = (shavv[7:1] == PORT_BASE[7:1]);
    assign wr  = sel & negedge_zpvv_n;
    assign rd  = sel & negedge_chtvv_n;

    ay_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_req),
        .din     (push_entry),
        .pop     (pop),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // CPU side: the write is applied before the read so a same-clk read sees it
    always_comb begin
        cpu_addr_d = cpu_addr_q;
        shadow_d   = shadow_q;
        data_o_d   = data_o_q;
        push_req   = 1'b0;
        push_entry = '{is_addr: CMD_DATA, data: data};
        if (wr) begin
            if (shavv[0]) begin
                cpu_addr_d = data;
                push_req   = 1'b1;
                push_entry = '{is_addr: CMD_ADDR, data: data};
            end else if (cpu_addr_q[7:4] == 4'h0) begin
                shadow_d[cpu_addr_q[3:0]] = data & REG_MASK[cpu_addr_q[3:0]];
                push_req                  = 1'b1;
            end
        end
        if (rd) begin
            if (!shavv[0] && cpu_addr_d[7:4] == 4'h0) begin
                data_o_d = shadow_d[cpu_addr_d[3:0]];
            end else begin
                data_o_d = 8'hFF;
            end
        end
        overflow_d = push_req & fifo_full & ~pop;
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        ym_di_d   = ym_di_q;
        is_addr_d = is_addr_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    ym_di_d   = head.data;
                    is_addr_d = (head.is_addr == CMD_ADDR);
                    state_d   = StSetup;
                end
            end
            StSetup:  if (ce) state_d = StStrobe;
            StStrobe: if (ce) state_d = StHold;
            StHold:   if (ce) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cpu_addr_q <= '0;
            shadow_q   <= '0;
            data_o_q   <= 8'hFF;
            ym_di_q    <= '0;
            is_addr_q  <= 1'b0;
            ym_bdir_q  <= 1'b0;
            ym_bc_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpu_addr_q <= cpu_addr_d;
            shadow_q   <= shadow_d;
            data_o_q   <= data_o_d;
            ym_di_q    <= ym_di_d;
            is_addr_q  <= is_addr_d;
            ym_bdir_q  <= (state_q == StStrobe);
            ym_bc_q    <= (state_q == StStrobe) & is_addr_q;
            overflow_q <= overflow_d;
        end
    end

    assign ym_di    = ym_di_q;
    assign ym_bdir  = ym_bdir_q;
    assign ym_bc    = ym_bc_q;
    assign data_o   = data_o_q;
    assign overflow = overflow_q;
    assign busy     = ~fifo_empty | (state_q != StIdle);

endmodule
